bs_gnrtr_n_rbtr: RTL and testbench
==================================

# bs_gnrtr_n_rbtr

Shared-bus generator and arbiter. It connects `drvrs` device FIFOs over one packet bus. It picks a pending source in round-robin order, pops that source's head packet, and pushes the packet to the device named in its header, or to every other device on a broadcast. It sits between the per-device driver FIFOs and the device receive FIFOs, and is the DUT of the bus verification environment.

## Interface
Parameters:
- `drvrs`, default 4: number of devices on the bus (2..255).
- `pckg_sz`, default 16: packet width in bits, ≥ 9.
- `broadcast`, default 8'hFF: destination ID meaning "all devices".

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `pndng`, input, [drvrs-1:0]: bit i high means FIFO i holds at least one packet.
- `D_pop`, input, [drvrs-1:0][pckg_sz-1:0]: head packet of each device FIFO; valid while `pndng[i]` is high.
- `pop`, output, [drvrs-1:0]: one-cycle pulse; FIFO i drops its head at the next edge.
- `push`, output, [drvrs-1:0]: one-cycle pulse; device i captures `D_push` at the next edge.
- `D_push`, output, [pckg_sz-1:0]: shared bus data.

## Operation
- Packet header: `ID = pkt[pckg_sz-1 -: 8]`. The remaining low bits are payload and are never modified.
- FSM states: IDLE, READ, WRITE. Outputs are Moore-decoded from registered state.
- IDLE:
  - `pop` = 0 and `push` = 0.
  - If `pndng` ≠ 0, select the first set bit searching upward (with wrap) from `last+1`.
  - Register the selection as `gnt` and go to READ. Otherwise stay in IDLE.
- READ:
  - `pop[gnt]` = 1.
  - At the closing edge: data register ← `D_pop[gnt]`, `last` ← `gnt`, go to WRITE.
- WRITE: `D_push` = data register, and the `push` target set is:
  - ID == `broadcast`: all bits except `gnt`.
  - ID < `drvrs`: `push[ID]` only, including ID == `gnt` (self-delivery allowed).
  - Otherwise: no bits. The packet is dropped but the source was still popped.
  - Always returns to IDLE.
- `D_push` holds the last transferred packet until the next capture.
- At most one bit of `pop` is ever high. `pop` and `push` are never high in the same cycle.
- `pndng` is sampled only in IDLE. A source deasserting `pndng` during READ is still popped; the source owns that protocol.

## Timing
- Reset (`reset` == 0 at an edge):
  - State → IDLE.
  - `last` → `drvrs-1`, so device 0 is searched first.
  - Data register → 0.
  - Next cycle: `pop` = 0, `push` = 0, `D_push` = 0.
  - Reset dominates every state. A packet popped but not yet pushed is lost.
- Latency:
  - Edge E samples `pndng` in IDLE.
  - `pop` is high during cycle E→E+1.
  - `push` and `D_push` are valid during cycle E+1→E+2.
- Throughput: one packet per 3 cycles with sources continuously pending.
- Fairness: each continuously pending device is granted at least once every `drvrs` transactions.

## Configuration
- `BS_GNRTR_BCAST_EN`:
  - Defined: broadcast ID handling as described in Operation.
  - Undefined: `broadcast` is an ordinary ID value. Values ≥ `drvrs` are dropped, with `pop` still issued and no `push`.

## Test plan
Defaults (`drvrs`=4, `pckg_sz`=16, `broadcast`=8'hFF, macro defined) unless stated.
- Reset: hold `reset`=0 for 2 edges with `pndng`=4'hF → `pop`=0, `push`=0, `D_push`=16'h0000 throughout. First grant after release goes to device 0.
- Unicast: `pndng`=4'b0010, `D_pop[1]`=16'h0255 → `pop`=4'b0010 for one cycle, then `push`=4'b0100 with `D_push`=16'h0255 for one cycle.
- Broadcast: `pndng`=4'b0001, `D_pop[0]`=16'hFFAB → `push`=4'b1110, `D_push`=16'hFFAB. With the macro undefined → `push`=4'b0000.
- Round-robin: `pndng`=4'hF held for 5 transactions → `pop` sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Invalid destination: `D_pop[2]`=16'h07C3, `pndng`=4'b0100 → `pop`=4'b0100, then a WRITE cycle with `push`=4'b0000.
- Reset mid-transfer: drive `reset`=0 at the edge entering WRITE → no `push` pulse, `D_push`=0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/bs_gnrtr_n_rbtr.sv
// -----------------------------------------------------------------------------
// bs_gnrtr_n_rbtr -- shared-bus generator and arbiter
//
// Picks a pending device FIFO in round-robin order, pops its head packet and
// pushes it onto the shared bus toward the device named in the packet header
// (ID = top 8 bits), or to every other device when the ID is the broadcast ID.
// One transfer takes three cycles: IDLE (arbitrate) -> READ (pop) -> WRITE
// (push).
//
// Parameters:
//   drvrs     number of devices on the bus (2..255)
//   pckg_sz   packet width in bits (>= 9)
//   broadcast destination ID meaning "all devices except the source"
//
// Ports:
//   clk     single clock, rising edge
//   reset   synchronous, active-low reset
//   pndng   per-device "FIFO not empty" flags
//   D_pop   per-device head packet, valid while pndng[i] is high
//   pop     one-cycle pulse, FIFO i drops its head at the next edge
//   push    one-cycle pulse, device i captures D_push at the next edge
//   D_push  shared bus data; holds the last transferred packet
//
// Configuration macro:
//   BS_GNRTR_BCAST_EN  defined   -> broadcast ID fans out to all other devices
//                      undefined -> broadcast is an ordinary ID (dropped when
//                                   it is >= drvrs)
// -----------------------------------------------------------------------------
module bs_gnrtr_n_rbtr #(
  parameter int            drvrs     = 4,
  parameter int            pckg_sz   = 16,
  parameter logic [7:0]    broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push
);

  localparam int               IDW      = $clog2(drvrs);
  localparam logic [IDW-1:0]   LAST_IDX = IDW'(drvrs - 1);
  localparam logic [drvrs-1:0] ONE      = drvrs'(1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [pckg_sz-1:0]   data_q, data_d;

  logic [IDW-1:0]       sel;
  logic                 found;
  logic [IDW-1:0]       cand;
  logic [7:0]           id;

  assign id     = data_q[pckg_sz-1 -: 8];
  assign D_push = data_q;

  // Round-robin search: walk upward from last+1 with wrap, first pending wins.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 0; k < drvrs; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDW'(1);
      if (!found && pndng[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = sel;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = D_pop[gnt_q];
        last_d  = gnt_q;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifndef BS_GNRTR_BCAST_EN
  // Broadcast ID has no special meaning in this build; it simply falls
  // through the ordinary destination decode below.
  logic [7:0] bcast_unused;
  assign bcast_unused = broadcast;
`endif

  // Moore outputs decoded from the registered state.
  always_comb begin
    pop  = '0;
    push = '0;
    case (state_q)
      READ: pop = ONE << gnt_q;
      WRITE: begin
`ifdef BS_GNRTR_BCAST_EN
        if (id == broadcast) begin
          push = ~(ONE << gnt_q);
        end else
`endif
        if (int'(id) < drvrs) begin
          // Self-delivery (id == gnt) is permitted.
          push = ONE << id;
        end
        // Any other ID: packet dropped, source was still popped.
      end
      default: begin
        pop  = '0;
        push = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_IDX;  // device 0 is searched first after reset
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// -----------------------------------------------------------------------------
// Directed testbench for bs_gnrtr_n_rbtr (drvrs=4, pckg_sz=16, broadcast=FF).
// Inputs change right after the falling edge; outputs are checked on the
// falling edge, half a cycle away from the rising edge the DUT uses.
// -----------------------------------------------------------------------------
module tb_bs_gnrtr_n_rbtr;

  logic                 clk;
  logic                 reset;
  logic [3:0]           pndng;
  logic [3:0][15:0]     d_pop;
  logic [3:0]           pop;
  logic [3:0]           push;
  logic [15:0]          d_push;

  int tests;
  int fails;

`ifdef BS_GNRTR_BCAST_EN
  localparam logic [3:0] BC_FROM3 = 4'b0111;
  localparam logic [3:0] BC_FROM0 = 4'b1110;
`else
  localparam logic [3:0] BC_FROM3 = 4'b0000;
  localparam logic [3:0] BC_FROM0 = 4'b0000;
`endif

  bs_gnrtr_n_rbtr #(
    .drvrs    (4),
    .pckg_sz  (16),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (d_pop),
    .pop   (pop),
    .push  (push),
    .D_push(d_push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check all outputs.
  task automatic cyc(input string tag, input logic [3:0] pop_e,
                     input logic [3:0] push_e, input logic [15:0] d_e);
    @(negedge clk);
    chk({tag, ".pop"},    {12'h0, pop},  {12'h0, pop_e});
    chk({tag, ".push"},   {12'h0, push}, {12'h0, push_e});
    chk({tag, ".D_push"}, d_push,        d_e);
    $display("[TB] %s pop=%b push=%b D_push=%h", tag, pop, push, d_push);
  endtask

  // One full transfer starting from IDLE: READ, WRITE, IDLE cycles.
  task automatic xfer(input string tag, input logic [3:0] pop_e,
                      input logic [3:0] push_e, input logic [15:0] d_e,
                      input logic [15:0] d_prev);
    cyc({tag, ".read"},  pop_e, 4'b0000, d_prev);
    cyc({tag, ".write"}, 4'b0000, push_e, d_e);
    cyc({tag, ".idle"},  4'b0000, 4'b0000, d_e);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b0;
    pndng    = 4'hF;
    d_pop[0] = 16'h0011;  // ID 0: self-delivery from device 0
    d_pop[1] = 16'h0255;  // ID 2: unicast
    d_pop[2] = 16'h07C3;  // ID 7: invalid destination
    d_pop[3] = 16'hFFAB;  // ID FF: broadcast

    // Reset held for two edges with everything pending.
    cyc("rst0", 4'b0000, 4'b0000, 16'h0000);
    cyc("rst1", 4'b0000, 4'b0000, 16'h0000);
    reset = 1'b1;

    // Round robin with all sources pending, first grant to device 0.
    xfer("rr0", 4'b0001, 4'b0001, 16'h0011, 16'h0000);
    xfer("rr1", 4'b0010, 4'b0100, 16'h0255, 16'h0011);
    xfer("rr2", 4'b0100, 4'b0000, 16'h07C3, 16'h0255);
    xfer("rr3", 4'b1000, BC_FROM3, 16'hFFAB, 16'h07C3);
    xfer("rr4", 4'b0001, 4'b0001, 16'h0011, 16'hFFAB);

    // Broadcast from device 0.
    pndng    = 4'b0001;
    d_pop[0] = 16'hFFAB;
    xfer("bcast", 4'b0001, BC_FROM0, 16'hFFAB, 16'h0011);

    // Single-source unicast.
    pndng = 4'b0010;
    xfer("uni", 4'b0010, 4'b0100, 16'h0255, 16'hFFAB);

    // Invalid destination alone: popped, nothing pushed.
    pndng = 4'b0100;
    xfer("inval", 4'b0100, 4'b0000, 16'h07C3, 16'h0255);

    // Skip non-pending devices: last=2, search from 3, then wrap to 0.
    pndng    = 4'b1001;
    d_pop[0] = 16'h0322;
    xfer("skip3", 4'b1000, BC_FROM3, 16'hFFAB, 16'h07C3);
    xfer("wrap0", 4'b0001, 4'b1000, 16'h0322, 16'hFFAB);

    // No requests: bus stays quiet, D_push holds.
    pndng = 4'b0000;
    cyc("quiet0", 4'b0000, 4'b0000, 16'h0322);
    cyc("quiet1", 4'b0000, 4'b0000, 16'h0322);

    // Reset at the edge that would enter WRITE: packet lost.
    pndng    = 4'b0100;
    d_pop[2] = 16'h0133;
    cyc("rstmid.read", 4'b0100, 4'b0000, 16'h0322);
    reset = 1'b0;
    pndng = 4'b0000;
    cyc("rstmid.cut", 4'b0000, 4'b0000, 16'h0000);
    reset = 1'b1;
    cyc("rstmid.idle", 4'b0000, 4'b0000, 16'h0000);

    // After reset the search restarts at device 0 again.
    pndng    = 4'hF;
    d_pop[0] = 16'h0011;
    xfer("post", 4'b0001, 4'b0001, 16'h0011, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
